// File: rtl/gb_lcd_pkg.sv
// Shared definitions for the DMG LCD link: panel geometry, framebuffer
// address width, pixel type and the transmitter FSM states. The capture
// reader imports the same package, so both ends agree on geometry.
package gb_lcd_pkg;

    // Panel geometry of the DMG LCD
    localparam int H_ACTIVE   = 160;   // pixels per line
    localparam int V_ACTIVE   = 144;   // active lines per frame
    localparam int V_TOTAL    = 154;   // lines per frame including vblank
    localparam int LINE_TOTAL = 228;   // cp periods per line
    localparam int HS_WIDTH   = 4;     // cp periods of hs at line start

    // Framebuffer geometry: 160 x 144 pixels, row stride fixed at 160
    localparam int FB_AW      = 15;
    localparam int FB_STRIDE  = 160;

    // Counter widths (x up to LINE_TOTAL-1, y up to V_TOTAL-1)
    localparam int X_W        = 8;
    localparam int Y_W        = 8;

    // One 2bpp pixel: bit 1 drives d1, bit 0 drives d0
    typedef logic [1:0] gb_pixel_t;

    // Transmitter FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } lcd_state_t;

    // Framebuffer address of pixel (px, y): y*160 + px, with the multiply
    // by 160 done as (y<<7) + (y<<5) so no multiplier is needed.
    function automatic logic [FB_AW-1:0] fb_addr_of(
        input logic [Y_W-1:0] y,
        input logic [X_W-1:0] px
    );
        logic [FB_AW-1:0] yw;
        yw = FB_AW'(y);
        return (yw << 7) + (yw << 5) + FB_AW'(px);
    endfunction

endpackage

// File: rtl/gb_lcd_cpgen.sv
// Pixel clock generator for the DMG LCD transmitter. A divider counts
// 0..CLK_DIV-1 per cp half-period and toggles the cp flop on wrap. The
// cp_rise / cp_fall strobes are high for the single clk cycle whose
// closing edge makes cp rise / fall, so the caller can update its own
// registers on exactly the same edge. While run is low cp is held low
// and the divider is parked at 0, so a new run always starts with a
// full low half-period.
module gb_lcd_cpgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic cp,
    output logic cp_rise,
    output logic cp_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             cp_q;
    logic             cp_d;
    logic             wrap;

    // Divider next-state: count while running, toggle cp on wrap
    always_comb begin
        wrap  = run && (div_q == DIV_W'(CLK_DIV - 1));
        div_d = div_q;
        cp_d  = cp_q;
        if (!run) begin
            div_d = '0;
            cp_d  = 1'b0;
        end else if (wrap) begin
            div_d = '0;
            cp_d  = ~cp_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider and cp flop; cp is driven straight from a flop so it never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            cp_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cp_q  <= cp_d;
        end
    end

    assign cp      = cp_q;
    assign cp_rise = wrap && !cp_q;
    assign cp_fall = wrap &&  cp_q;

endmodule

// File: rtl/gb_lcd_tx.sv
// DMG LCD link transmitter. Reads a 160x144x2bpp framebuffer through a
// synchronous read port and drives cp/hs/vs/d0/d1 the way a DMG LCD port
// does. x counts cp periods within a line, y counts lines within a frame.
// Each cp period starts at a cp falling edge: hs/vs/d are registered on
// that edge and stay stable through the following rising edge, where the
// receiver samples them. The address of the next pixel is issued on the
// rising edge, giving the RAM at least CLK_DIV clks before the data is
// captured on the next falling edge.
module gb_lcd_tx #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = gb_lcd_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = gb_lcd_pkg::V_ACTIVE,
    parameter int V_TOTAL    = gb_lcd_pkg::V_TOTAL,
    parameter int LINE_TOTAL = gb_lcd_pkg::LINE_TOTAL,
    parameter int HS_WIDTH   = gb_lcd_pkg::HS_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic [gb_lcd_pkg::FB_AW-1:0] fb_addr,
    input  logic [1:0]                   fb_q,
    output logic                         cp,
    output logic                         hs,
    output logic                         vs,
    output logic                         d0,
    output logic                         d1,
    output logic                         frame_sof,
    output logic                         busy
);

    import gb_lcd_pkg::FB_AW;
    import gb_lcd_pkg::X_W;
    import gb_lcd_pkg::Y_W;
    import gb_lcd_pkg::gb_pixel_t;
    import gb_lcd_pkg::lcd_state_t;
    import gb_lcd_pkg::ST_IDLE;
    import gb_lcd_pkg::ST_FRAME;
    import gb_lcd_pkg::fb_addr_of;

    // Registered state and outputs
    lcd_state_t        state_q,   state_d;
    logic [X_W-1:0]    x_q,       x_d;
    logic [Y_W-1:0]    y_q,       y_d;
    logic              hs_q,      hs_d;
    logic              vs_q,      vs_d;
    gb_pixel_t         pix_q,     pix_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic              sof_q,     sof_d;
    logic              busy_q,    busy_d;

    // Pixel clock strobes
    logic              run;
    logic              cp_rise;
    logic              cp_fall;

    // Position of the cp period that follows the current one
    logic              line_end;
    logic              frame_end;
    logic [X_W-1:0]    x_next;
    logic [Y_W-1:0]    y_next;
    logic [X_W-1:0]    px_next;

    // True when cp period x of line y carries a framebuffer pixel
    function automatic logic is_active(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return (int'(y) < V_ACTIVE) &&
               (int'(x) >= HS_WIDTH) &&
               (int'(x) <  HS_WIDTH + H_ACTIVE);
    endfunction

    assign run = (state_q == ST_FRAME);

    gb_lcd_cpgen #(
        .CLK_DIV (CLK_DIV)
    ) u_cpgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .cp      (cp),
        .cp_rise (cp_rise),
        .cp_fall (cp_fall)
    );

    // The line wrap always lands on x=0, which lies inside hsync, so the
    // next-pixel test never has to look across a line boundary.
    assign line_end  = (x_q == X_W'(LINE_TOTAL - 1));
    assign frame_end = line_end && (y_q == Y_W'(V_TOTAL - 1));
    assign x_next    = line_end ? '0 : x_q + X_W'(1);
    assign y_next    = line_end ? (frame_end ? '0 : y_q + Y_W'(1)) : y_q;
    assign px_next   = x_next - X_W'(HS_WIDTH);

    // FSM, counters, fetch address and output registers: next-state logic
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        pix_d     = pix_q;
        fb_addr_d = fb_addr_q;
        sof_d     = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    // First period of line 0 starts now with cp low
                    state_d = ST_FRAME;
                    x_d     = '0;
                    y_d     = '0;
                    hs_d    = 1'b1;
                    vs_d    = 1'b1;
                    pix_d   = '0;
                    sof_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            ST_FRAME: begin
                // Issue the address of the pixel shown in the next period
                if (cp_rise && is_active(x_next, y_q)) begin
                    fb_addr_d = fb_addr_of(y_q, px_next);
                end

                // Advance one cp period; capture RAM data for it
                if (cp_fall) begin
                    if (frame_end && !enable) begin
                        state_d = ST_IDLE;
                        x_d     = '0;
                        y_d     = '0;
                        hs_d    = 1'b0;
                        vs_d    = 1'b0;
                        pix_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        x_d    = x_next;
                        y_d    = y_next;
                        hs_d   = (int'(x_next) < HS_WIDTH);
                        vs_d   = (y_next == '0);
                        pix_d  = is_active(x_next, y_next) ? gb_pixel_t'(fb_q) : '0;
                        sof_d  = frame_end;
                        busy_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, fetch address and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            pix_q     <= '0;
            fb_addr_q <= '0;
            sof_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            pix_q     <= pix_d;
            fb_addr_q <= fb_addr_d;
            sof_q     <= sof_d;
            busy_q    <= busy_d;
        end
    end

    assign fb_addr   = fb_addr_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign d0        = pix_q[0];
    assign d1        = pix_q[1];
    assign frame_sof = sof_q;
    assign busy      = busy_q;

endmodule
